// File: rtl/spi_frame_tx.sv
// spi_frame_tx: serializes sync/addr/len/payload/checksum frames onto a byte valid/ready link,
// fetching payload bytes from a synchronous buffer with one-cycle read latency.
module spi_frame_tx #(
  parameter logic [7:0] SYNC_BYTE = 8'h77,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [15:0]      addr,
  input  logic [LEN_W-1:0] len,
  output logic             rd_en,
  output logic [LEN_W-1:0] rd_addr,
  input  logic [7:0]       rd_data,
  output logic [7:0]       data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             busy,
  output logic             done
);
  typedef enum logic [3:0] {IDLE, SYNC, ADDR_H, ADDR_L, LEN_H, LEN_L, FETCH, RDWAIT, PAYLOAD, CSUM} state_t;
  state_t state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [LEN_W-1:0] len_q, len_d, idx_q, idx_d, rd_addr_q, rd_addr_d;
  logic [7:0] csum_q, csum_d, dout_q, dout_d, csum_nx;
  logic valid_q, valid_d, rd_en_q, rd_en_d, done_q, done_d, xfer;
  assign xfer = valid_q & data_ready;
  assign csum_nx = csum_q + dout_q;
  assign rd_en = rd_en_q;
  assign rd_addr = rd_addr_q;
  assign data_out = dout_q;
  assign data_valid = valid_q;
  assign busy = state_q != IDLE;
  assign done = done_q;
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    len_d = len_q;
    idx_d = idx_q;
    dout_d = dout_q;
    valid_d = valid_q;
    rd_en_d = 1'b0;
    rd_addr_d = rd_addr_q;
    done_d = 1'b0;
    csum_d = (xfer && state_q != SYNC && state_q != CSUM) ? csum_nx : csum_q;
    case (state_q)
      IDLE: if (start) begin
        addr_d = addr;
        len_d = len;
        csum_d = '0;
        dout_d = SYNC_BYTE;
        valid_d = 1'b1;
        state_d = SYNC;
      end
      SYNC: if (xfer) begin
        dout_d = addr_q[15:8];
        state_d = ADDR_H;
      end
      ADDR_H: if (xfer) begin
        dout_d = addr_q[7:0];
        state_d = ADDR_L;
      end
      ADDR_L: if (xfer) begin
        dout_d = len_q[15:8];
        state_d = LEN_H;
      end
      LEN_H: if (xfer) begin
        dout_d = len_q[7:0];
        state_d = LEN_L;
      end
      LEN_L: if (xfer) begin
        if (len_q == '0) begin
          dout_d = csum_nx;
          state_d = CSUM;
        end else begin
          valid_d = 1'b0;
          rd_en_d = 1'b1;
          rd_addr_d = '0;
          idx_d = '0;
          state_d = FETCH;
        end
      end
      FETCH: state_d = RDWAIT;
      RDWAIT: begin
        dout_d = rd_data;
        valid_d = 1'b1;
        state_d = PAYLOAD;
      end
      PAYLOAD: if (xfer) begin
        if (idx_q == len_q - 1'b1) begin
          dout_d = csum_nx;
          state_d = CSUM;
        end else begin
          idx_d = idx_q + 1'b1;
          rd_addr_d = idx_q + 1'b1;
          rd_en_d = 1'b1;
          valid_d = 1'b0;
          state_d = FETCH;
        end
      end
      CSUM: if (xfer) begin
        valid_d = 1'b0;
        done_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      len_q <= '0;
      idx_q <= '0;
      csum_q <= '0;
      dout_q <= '0;
      valid_q <= 1'b0;
      rd_en_q <= 1'b0;
      rd_addr_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      len_q <= len_d;
      idx_q <= idx_d;
      csum_q <= csum_d;
      dout_q <= dout_d;
      valid_q <= valid_d;
      rd_en_q <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      done_q <= done_d;
    end
  end
endmodule

// File: tb/tb_spi_frame_tx.sv
// tb_spi_frame_tx: scoreboard bench; stimulus queues expected bytes, a negedge monitor pops on each transfer.
module tb_spi_frame_tx;
  logic clk = 1'b0;
  logic rst, start, data_ready, rd_en, data_valid, busy, done;
  logic [15:0] addr, len, rd_addr;
  logic [7:0] rd_data, data_out;
  logic [7:0] buf_mem [0:15];
  logic [7:0] exp_q [$];
  logic [15:0] cur_len = 16'd0;
  int checks = 0, failures = 0, done_cnt = 0, rd_cnt = 0, ready_mode = 0;
  logic prev_valid = 1'b0, prev_ready = 1'b0, prev_done = 1'b0;
  logic [7:0] prev_out = 8'd0;

  always #5 clk = ~clk;

  spi_frame_tx dut (
    .clk(clk), .rst(rst), .start(start), .addr(addr), .len(len),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
    .busy(busy), .done(done)
  );

  always @(posedge clk) if (rd_en) rd_data <= buf_mem[rd_addr[3:0]];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  initial begin
    data_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      data_ready = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? ~data_ready : 1'b0;
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (prev_valid && !prev_ready && data_valid) chk("hold_stable", data_out, prev_out);
      if (prev_done) chk("done_width", done, 0);
      if (done) done_cnt++;
      if (rd_en) begin
        rd_cnt++;
        chk("rd_addr_range", rd_addr < cur_len, 1);
      end
      if (data_valid && data_ready) begin
        if (exp_q.size() == 0) chk("byte_expected", 0, 1);
        else chk("byte", data_out, exp_q.pop_front());
      end
    end
    prev_valid = data_valid;
    prev_ready = data_ready;
    prev_out = data_out;
    prev_done = done;
  end

  task automatic queue_frame(input logic [15:0] a, input logic [15:0] l);
    logic [7:0] s;
    s = a[15:8] + a[7:0] + l[15:8] + l[7:0];
    exp_q.push_back(8'h77);
    exp_q.push_back(a[15:8]);
    exp_q.push_back(a[7:0]);
    exp_q.push_back(l[15:8]);
    exp_q.push_back(l[7:0]);
    for (int i = 0; i < int'(l); i++) begin
      exp_q.push_back(buf_mem[i]);
      s = s + buf_mem[i];
    end
    exp_q.push_back(s);
    cur_len = l;
  endtask

  task automatic pulse_start(input logic [15:0] a, input logic [15:0] l);
    addr = a;
    len = l;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (!done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_done_seen"}, done, 1);
  endtask

  task automatic frame_end(input string nm, input int exp_done);
    wait_done(nm);
    @(negedge clk);
    chk({nm, "_queue_empty"}, exp_q.size(), 0);
    chk({nm, "_busy_low"}, {busy, done}, 0);
    chk({nm, "_done_count"}, done_cnt, exp_done);
  endtask

  initial begin
    int d0, r0, n;
    rst = 1'b1;
    start = 1'b0;
    addr = '0;
    len = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {data_valid, busy, rd_en, done, data_out, rd_addr}, 0);
    rst = 1'b0;
    @(negedge clk);

    buf_mem[0] = 8'hAA;
    queue_frame(16'h0123, 16'd1);
    d0 = done_cnt;
    pulse_start(16'h0123, 16'd1);
    chk("t1_start", {busy, data_valid, data_out}, {2'b11, 8'h77});
    frame_end("t1", d0 + 1);

    queue_frame(16'h0000, 16'd0);
    d0 = done_cnt;
    r0 = rd_cnt;
    pulse_start(16'h0000, 16'd0);
    frame_end("t2", d0 + 1);
    chk("t2_no_rd_en", rd_cnt, r0);

    buf_mem[0] = 8'h10;
    buf_mem[1] = 8'h20;
    buf_mem[2] = 8'h30;
    ready_mode = 1;
    queue_frame(16'h8001, 16'd3);
    d0 = done_cnt;
    pulse_start(16'h8001, 16'd3);
    frame_end("t3", d0 + 1);
    ready_mode = 0;

    buf_mem[0] = 8'h5A;
    buf_mem[1] = 8'hA5;
    queue_frame(16'h1234, 16'd2);
    d0 = done_cnt;
    pulse_start(16'h1234, 16'd2);
    repeat (3) @(negedge clk);
    pulse_start(16'hFFFF, 16'd9);
    wait_done("t4a");
    buf_mem[0] = 8'h3C;
    queue_frame(16'h0042, 16'd1);
    pulse_start(16'h0042, 16'd1);
    chk("t4_restart_accepted", {busy, data_valid, data_out}, {2'b11, 8'h77});
    frame_end("t4b", d0 + 2);

    buf_mem[0] = 8'h01;
    buf_mem[1] = 8'h02;
    buf_mem[2] = 8'h03;
    buf_mem[3] = 8'h04;
    queue_frame(16'h4444, 16'd4);
    pulse_start(16'h4444, 16'd4);
    n = 0;
    while (exp_q.size() > 3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t5_reached_payload", exp_q.size() <= 3, 1);
    rst = 1'b1;
    d0 = done_cnt;
    @(negedge clk);
    chk("t5_abort_outputs", {data_valid, busy, rd_en, done, data_out, rd_addr}, 0);
    rst = 1'b0;
    exp_q.delete();
    repeat (5) @(negedge clk);
    chk("t5_no_done", done_cnt, d0);
    buf_mem[0] = 8'h09;
    buf_mem[1] = 8'h08;
    queue_frame(16'h0BAD, 16'd2);
    pulse_start(16'h0BAD, 16'd2);
    frame_end("t5", d0 + 1);

    buf_mem[0] = 8'hC1;
    buf_mem[1] = 8'hC2;
    ready_mode = 2;
    data_ready = 1'b0;
    queue_frame(16'h0202, 16'd2);
    d0 = done_cnt;
    pulse_start(16'h0202, 16'd2);
    for (int i = 0; i < 10; i++) begin
      chk("t6_sync_hold", {data_valid, data_out}, {1'b1, 8'h77});
      @(negedge clk);
    end
    ready_mode = 0;
    frame_end("t6", d0 + 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
